jtframe_mcu_mailbox: RTL and testbench

Parametrised mailbox bridge between an 8051-family MCU external-data bus and the main CPU. It is the generalised successor of the fixed single-port xdata hook-up. It provides CH bidirectional latch channels of DW bits with full flags, a status register, interrupt generation toward both sides and an optional cen-synchronised pass-through for non-mailbox xdata. It sits between the MCU core's adrx/datax/wrx signals and the main CPU bus decoder.

---
 rtl/jtframe_mcu_mailbox.sv | 125 ++++++++++++
 tb/tb_jtframe_mcu_mailbox.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_mcu_mailbox.sv
// jtframe_mcu_mailbox: CH-channel bidirectional latch mailbox between an 8051 xdata bus
// and the main CPU. It provides full flags, a shared status word, interrupts toward both
// sides and an optional cen-synchronised pass-through for xdata outside the window.
module jtframe_mcu_mailbox #(
   parameter int          DW       = 8,
   parameter int          CH       = 2,
   parameter int          AW       = 16,
   parameter int unsigned BASE     = 0,
   parameter int          SYNC_X   = 0,
   parameter int          INT_MODE = 0,
   parameter int          PULSE    = 4,
   localparam int         MW       = $clog2(CH+1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cen,
   input  logic [AW-1:0] mcu_addr,
   input  logic [DW-1:0] mcu_dout,
   input  logic          mcu_wr,
   input  logic          mcu_rd,
   input  logic [DW-1:0] mcu_xin,
   output logic [DW-1:0] mcu_din,
   output logic          mcu_intn,
   input  logic [MW-1:0] main_addr,
   input  logic [DW-1:0] main_dout,
   input  logic          main_we,
   input  logic          main_rd,
   output logic [DW-1:0] main_din,
   output logic          main_intn,
   output logic [CH-1:0] m2s_full,
   output logic [CH-1:0] s2m_full
);

   localparam logic [AW-1:0] BASE_A   = AW'(BASE);
   localparam logic [AW-1:0] STAT_OFF = AW'(CH);
   localparam logic [MW-1:0] STAT_M   = MW'(CH);

   logic [DW-1:0] m2s [CH];
   logic [DW-1:0] s2m [CH];
   logic [CH-1:0] m2s_full_d, s2m_full_d;
   logic          mcu_rd_l, main_rd_l;
   logic [DW-1:0] xin_q;
   logic [7:0]    pcnt, pcnt_d;
   logic [DW-1:0] status, main_din_d;
   logic [AW:0]   mcu_diff;
   logic [AW-1:0] mcu_off;
   logic          mcu_win, mcu_rd_edge, mcu_wr_cyc, main_rd_edge, main_wr_ch;

   // Borrow bit of the subtraction tells addresses below BASE apart
   assign mcu_diff     = {1'b0, mcu_addr} - {1'b0, BASE_A};
   assign mcu_off      = mcu_diff[AW-1:0];
   assign mcu_win      = !mcu_diff[AW] && (mcu_off <= STAT_OFF);
   assign mcu_rd_edge  = cen & mcu_rd & ~mcu_rd_l & mcu_win;
   assign mcu_wr_cyc   = cen & mcu_wr & mcu_win;
   assign main_rd_edge = main_rd & ~main_rd_l;
   assign main_wr_ch   = main_we && (main_addr < STAT_M);
   assign status       = DW'({s2m_full, m2s_full});

   // Flag next state: clears are applied first so that a same-cycle set wins
   always_comb begin
      m2s_full_d = m2s_full;
      s2m_full_d = s2m_full;
      for (int c = 0; c < CH; c++) begin
         if (mcu_rd_edge && mcu_off == AW'(c))    m2s_full_d[c] = 1'b0;
         if (main_rd_edge && main_addr == MW'(c)) s2m_full_d[c] = 1'b0;
         if (main_we && main_addr == MW'(c))      m2s_full_d[c] = 1'b1;
         if (mcu_wr_cyc && mcu_off == AW'(c))     s2m_full_d[c] = 1'b1;
      end
   end

   // Interrupt pulse counter: reload on each main write, count down on cen
   always_comb begin
      pcnt_d = pcnt;
      if (main_wr_ch)              pcnt_d = 8'(PULSE);
      else if (cen && pcnt != '0) pcnt_d = pcnt - 8'd1;
   end

   // Read muxes: main side is registered below, MCU side is combinational
   always_comb begin
      main_din_d = '0;
      if (main_addr == STAT_M) main_din_d = status;
      mcu_din = (SYNC_X != 0) ? xin_q : mcu_xin;
      if (mcu_win) mcu_din = status;
      for (int c = 0; c < CH; c++) begin
         if (main_addr == MW'(c))          main_din_d = s2m[c];
         if (mcu_win && mcu_off == AW'(c)) mcu_din    = m2s[c];
      end
   end

   // All mailbox state, edge trackers and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < CH; c++) begin
            m2s[c] <= '0;
            s2m[c] <= '0;
         end
         m2s_full  <= '0;
         s2m_full  <= '0;
         mcu_rd_l  <= 1'b0;
         main_rd_l <= 1'b0;
         xin_q     <= '0;
         pcnt      <= '0;
         main_din  <= '0;
         mcu_intn  <= 1'b1;
         main_intn <= 1'b1;
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (main_we && main_addr == MW'(c))   m2s[c] <= main_dout;
            if (mcu_wr_cyc && mcu_off == AW'(c)) s2m[c] <= mcu_dout;
         end
         m2s_full  <= m2s_full_d;
         s2m_full  <= s2m_full_d;
         main_rd_l <= main_rd;
         if (cen) begin
            mcu_rd_l <= mcu_rd;
            xin_q    <= mcu_xin;
         end
         pcnt      <= pcnt_d;
         main_din  <= main_din_d;
         mcu_intn  <= (INT_MODE != 0) ? (pcnt_d == 8'd0) : ~|m2s_full_d;
         main_intn <= ~|s2m_full_d;
      end
   end

endmodule

// File: tb/tb_jtframe_mcu_mailbox.sv
// Self-checking bench for jtframe_mcu_mailbox: two instances share stimulus, one in level
// interrupt / direct pass-through mode, one in pulse interrupt / synchronised pass-through.
`timescale 1ns/1ps
module tb_jtframe_mcu_mailbox;
   localparam int DW = 8, CH = 2, AW = 16, MW = 2;
   localparam int BASE = 'h30;

   logic          clk = 1'b0, rstn = 1'b0, cen = 1'b0;
   logic [AW-1:0] mcu_addr = '0;
   logic [DW-1:0] mcu_dout = '0, mcu_xin = '0, main_dout = '0;
   logic          mcu_wr = 1'b0, mcu_rd = 1'b0, main_we = 1'b0, main_rd = 1'b0;
   logic [MW-1:0] main_addr = '0;

   logic [DW-1:0] a_mcu_din, a_main_din, b_mcu_din, b_main_din;
   logic          a_mcu_intn, a_main_intn, b_mcu_intn, b_main_intn;
   logic [CH-1:0] a_m2s_full, a_s2m_full, b_m2s_full, b_s2m_full;

   always #5 clk = ~clk;

   jtframe_mcu_mailbox #(.DW(DW), .CH(CH), .AW(AW), .BASE(BASE), .SYNC_X(0), .INT_MODE(0),
                         .PULSE(4)) u_a (
      .clk(clk), .rstn(rstn), .cen(cen), .mcu_addr(mcu_addr), .mcu_dout(mcu_dout),
      .mcu_wr(mcu_wr), .mcu_rd(mcu_rd), .mcu_xin(mcu_xin), .mcu_din(a_mcu_din),
      .mcu_intn(a_mcu_intn), .main_addr(main_addr), .main_dout(main_dout),
      .main_we(main_we), .main_rd(main_rd), .main_din(a_main_din), .main_intn(a_main_intn),
      .m2s_full(a_m2s_full), .s2m_full(a_s2m_full));

   jtframe_mcu_mailbox #(.DW(DW), .CH(CH), .AW(AW), .BASE(BASE), .SYNC_X(1), .INT_MODE(1),
                         .PULSE(3)) u_b (
      .clk(clk), .rstn(rstn), .cen(cen), .mcu_addr(mcu_addr), .mcu_dout(mcu_dout),
      .mcu_wr(mcu_wr), .mcu_rd(mcu_rd), .mcu_xin(mcu_xin), .mcu_din(b_mcu_din),
      .mcu_intn(b_mcu_intn), .main_addr(main_addr), .main_dout(main_dout),
      .main_we(main_we), .main_rd(main_rd), .main_din(b_main_din), .main_intn(b_main_intn),
      .m2s_full(b_m2s_full), .s2m_full(b_s2m_full));

   // Reference model: mailbox contents and flags as plain arrays
   logic [DW-1:0] m_m2s [CH];
   logic [DW-1:0] m_s2m [CH];
   logic [CH-1:0] m_m2sf, m_s2mf;
   logic [DW-1:0] m_xq;
   logic [DW-1:0] q_mcu_a [$];
   logic [DW-1:0] q_mcu_b [$];
   logic [DW-1:0] q_main  [$];
   int errors = 0, checks = 0;

   function automatic logic [DW-1:0] m_status();
      return DW'({m_s2mf, m_m2sf});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_m2s[c] = '0;
         m_s2m[c] = '0;
      end
      m_m2sf = '0;
      m_s2mf = '0;
      m_xq   = '0;
   endtask

   // One clock; the external-data sampler of the sync instance captures on cen
   task automatic tick();
      logic c;
      logic [DW-1:0] x;
      c = cen;
      x = mcu_xin;
      @(posedge clk);
      #1;
      if (c && rstn) m_xq = x;
   endtask

   task automatic check_flags();
      check("a_m2s_full", 32'(a_m2s_full), 32'(m_m2sf));
      check("a_s2m_full", 32'(a_s2m_full), 32'(m_s2mf));
      check("a_mcu_intn", 32'(a_mcu_intn), 32'(m_m2sf == '0));
      check("a_main_intn", 32'(a_main_intn), 32'(m_s2mf == '0));
      check("b_m2s_full", 32'(b_m2s_full), 32'(m_m2sf));
      check("b_s2m_full", 32'(b_s2m_full), 32'(m_s2mf));
      check("b_main_intn", 32'(b_main_intn), 32'(m_s2mf == '0));
   endtask

   // Idle gap after an MCU access; ends with a cen cycle with strobes low
   task automatic mcu_gap();
      cen = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      cen = 1'b1;
      tick();
      cen = 1'b0;
   endtask

   task automatic main_write(input int a, input logic [DW-1:0] d);
      main_addr = MW'(a);
      main_dout = d;
      main_we   = 1'b1;
      cen       = 1'b0;
      tick();
      main_we = 1'b0;
      if (a < CH) begin
         m_m2s[a]  = d;
         m_m2sf[a] = 1'b1;
      end
   endtask

   task automatic main_read(input int a);
      if (a < CH)       q_main.push_back(m_s2m[a]);
      else if (a == CH) q_main.push_back(m_status());
      else              q_main.push_back('0);
      main_addr = MW'(a);
      main_rd   = 1'b1;
      cen       = 1'b0;
      tick();
      main_rd = 1'b0;
      if (a < CH) m_s2mf[a] = 1'b0;
      tick();
   endtask

   task automatic mcu_write(input int off, input logic [DW-1:0] d);
      mcu_addr = AW'(BASE + off);
      mcu_dout = d;
      mcu_wr   = 1'b1;
      cen      = 1'b1;
      tick();
      mcu_wr = 1'b0;
      if (off < CH) begin
         m_s2m[off]  = d;
         m_s2mf[off] = 1'b1;
      end
      mcu_gap();
   endtask

   task automatic mcu_read(input logic [AW-1:0] addr);
      int off;
      off = int'(addr) - BASE;
      if (off >= 0 && off < CH) begin
         q_mcu_a.push_back(m_m2s[off]);
         q_mcu_b.push_back(m_m2s[off]);
      end else if (off == CH) begin
         q_mcu_a.push_back(m_status());
         q_mcu_b.push_back(m_status());
      end else begin
         q_mcu_a.push_back(mcu_xin);
         q_mcu_b.push_back(m_xq);
      end
      mcu_addr = addr;
      mcu_rd   = 1'b1;
      cen      = 1'b1;
      tick();
      mcu_rd = 1'b0;
      if (off >= 0 && off < CH) m_m2sf[off] = 1'b0;
      mcu_gap();
   endtask

   // Counts cen cycles during which the pulse-mode interrupt is low after a main write
   task automatic measure_pulse(input int reload_at, output int lowcnt);
      bit reloaded, done;
      lowcnt   = 0;
      reloaded = 1'b0;
      done     = 1'b0;
      main_write(0, DW'($urandom));
      for (int i = 0; i < 60 && !done; i++) begin
         cen = i[0];
         if (b_mcu_intn) begin
            done = 1'b1;
         end else begin
            if (reload_at > 0 && !reloaded && lowcnt == reload_at && !cen) begin
               main_addr = '0;
               main_dout = DW'($urandom);
               main_we   = 1'b1;
               reloaded  = 1'b1;
            end
            if (cen) lowcnt++;
            tick();
            if (main_we) begin
               main_we   = 1'b0;
               m_m2s[0]  = main_dout;
               m_m2sf[0] = 1'b1;
            end
         end
      end
      cen = 1'b0;
      check("pulse_ends", 32'(done), 32'd1);
   endtask

   // Monitor: compares read data whenever a read is presented to the DUT
   bit rd_seen = 1'b0;
   always @(negedge clk) begin
      logic [DW-1:0] ea, eb;
      if (!rstn) begin
         rd_seen = 1'b0;
      end else begin
         if (rd_seen) begin
            if (q_main.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL main_queue: response with no expectation at %0t", $time);
            end else begin
               ea = q_main.pop_front();
               check("a_main_din", 32'(a_main_din), 32'(ea));
               check("b_main_din", 32'(b_main_din), 32'(ea));
            end
         end
         rd_seen = main_rd;
         if (mcu_rd && cen) begin
            if (q_mcu_a.size() == 0 || q_mcu_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mcu_queue: read with no expectation at %0t", $time);
            end else begin
               ea = q_mcu_a.pop_front();
               eb = q_mcu_b.pop_front();
               check("a_mcu_din", 32'(a_mcu_din), 32'(ea));
               check("b_mcu_din", 32'(b_mcu_din), 32'(eb));
            end
         end
      end
   end

   initial begin
      int n;
      model_reset();
      // Reset held with strobes toggling
      rstn     = 1'b0;
      mcu_addr = AW'(BASE);
      for (int i = 0; i < 4; i++) begin
         cen     = 1'b1;
         mcu_rd  = ~mcu_rd;
         mcu_wr  = ~mcu_wr;
         main_we = ~main_we;
         main_rd = ~main_rd;
         main_dout = 8'hFF;
         mcu_dout  = 8'hEE;
         tick();
      end
      {mcu_rd, mcu_wr, main_we, main_rd, cen} = '0;
      check_flags();
      check("rst_a_main_din", 32'(a_main_din), 32'd0);
      check("rst_b_mcu_intn", 32'(b_mcu_intn), 32'd1);
      rstn = 1'b1;
      tick();

      // Main to MCU
      main_write(1, 8'h5A);
      check("m2s_after_wr", 32'(a_m2s_full), 32'h2);
      check_flags();
      mcu_read(AW'(BASE + 2));
      mcu_read(AW'(BASE + 1));
      check_flags();
      // MCU to main
      mcu_write(0, 8'hC3);
      check_flags();
      main_read(0);
      check_flags();
      // Collision: main write and MCU read edge on channel 0 in the same cycle
      main_write(0, 8'h22);
      q_mcu_a.push_back(8'h22);
      q_mcu_b.push_back(8'h22);
      mcu_addr  = AW'(BASE);
      mcu_rd    = 1'b1;
      cen       = 1'b1;
      main_addr = '0;
      main_dout = 8'h11;
      main_we   = 1'b1;
      tick();
      {mcu_rd, main_we} = '0;
      m_m2s[0]  = 8'h11;
      m_m2sf[0] = 1'b1;
      mcu_gap();
      check("collision_flag", 32'(a_m2s_full[0]), 32'd1);
      mcu_read(AW'(BASE));
      check_flags();

      // Randomised traffic
      for (int i = 0; i < 250; i++) begin
         mcu_xin = DW'($urandom);
         case ($urandom_range(0, 3))
            0: main_write($urandom_range(0, CH), DW'($urandom));
            1: main_read($urandom_range(0, 3));
            2: mcu_write($urandom_range(0, CH), DW'($urandom));
            default: begin
               if ($urandom_range(0, 3) == 0) mcu_read(AW'(16'h1000 + $urandom_range(0, 255)));
               else                           mcu_read(AW'(BASE + $urandom_range(0, CH)));
            end
         endcase
         check_flags();
      end

      // External pass-through: direct vs cen-synchronised
      mcu_addr = 16'h2000;
      mcu_xin  = 8'h00;
      cen      = 1'b1;
      tick();
      cen     = 1'b0;
      mcu_xin = 8'h7E;
      #1;
      check("xin_direct", 32'(a_mcu_din), 32'h7E);
      check("xin_sync_hold", 32'(b_mcu_din), 32'h00);
      tick();
      check("xin_sync_nocen", 32'(b_mcu_din), 32'h00);
      cen = 1'b1;
      tick();
      cen = 1'b0;
      check("xin_sync_cen", 32'(b_mcu_din), 32'h7E);

      // Pulse interrupt length and reload
      cen = 1'b1;
      repeat (10) tick();
      cen = 1'b0;
      check("pulse_idle", 32'(b_mcu_intn), 32'd1);
      measure_pulse(0, n);
      check("pulse_len", 32'(n), 32'd3);
      measure_pulse(1, n);
      check("pulse_reload", 32'(n), 32'd4);
      check_flags();

      // Asynchronous reset mid-transfer, read strobe held across release
      main_write(1, 8'hAA);
      mcu_write(1, 8'h55);
      mcu_addr = AW'(BASE);
      mcu_rd   = 1'b1;
      rstn     = 1'b0;
      #1;
      model_reset();
      check_flags();
      check("rst_mid_a_mcu_intn", 32'(a_mcu_intn), 32'd1);
      repeat (2) tick();
      rstn = 1'b1;
      main_write(0, 8'h3C);
      check_flags();
      q_mcu_a.push_back(8'h3C);
      q_mcu_b.push_back(8'h3C);
      cen = 1'b1;
      tick();
      mcu_rd    = 1'b0;
      m_m2sf[0] = 1'b0;
      mcu_gap();
      check_flags();

      repeat (3) tick();
      if (q_mcu_a.size() != 0 || q_mcu_b.size() != 0 || q_main.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL queues_drained: %0d/%0d/%0d left", q_mcu_a.size(), q_mcu_b.size(),
                  q_main.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
